// File: rtl/axil_reg_pkg.sv
// rtl/axil_reg_pkg.sv - register map constants and helpers for axil_reg_slave
package axil_reg_pkg;

    localparam int          WIN_BITS     = 5;
    localparam logic [31:0] DEF_ID_VALUE = 32'h4E41_0001;

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_IRQ_EN   = 3'd1,
        OFF_STATUS   = 3'd2,
        OFF_SCRATCH0 = 3'd3,
        OFF_SCRATCH1 = 3'd4,
        OFF_SCRATCH2 = 3'd5,
        OFF_ID       = 3'd6,
        OFF_CYCLES   = 3'd7
    } reg_off_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// rtl/axil_wr_capture.sv - independent AW/W holding registers with commit and B response
module axil_wr_capture (
    input  logic        clk,
    input  logic        resetn,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic        commit_o,
    output logic [31:0] commit_addr_o,
    output logic [31:0] commit_data_o,
    output logic [3:0]  commit_strb_o
);

    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        bvalid_q, bvalid_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        aw_hs, w_hs;

    assign awready_o = !aw_held_q && !bvalid_q;
    assign wready_o  = !w_held_q && !bvalid_q;
    assign bvalid_o  = bvalid_q;

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;

    // Commit as soon as both halves are present, held or arriving this edge.
    assign commit_o      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign commit_addr_o = aw_held_q ? aw_addr_q : awaddr_i;
    assign commit_data_o = w_held_q ? w_data_q : wdata_i;
    assign commit_strb_o = w_held_q ? w_strb_q : wstrb_i;

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr_i;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wdata_i;
            w_strb_d = wstrb_i;
        end
        if (bvalid_q && bready_i) bvalid_d = 1'b0;
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite control/status register bank; AXIL_REG_SLAVE_CYCLES_EN adds CYCLES counter
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter logic [31:0] ID_VALUE  = DEF_ID_VALUE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ext_awvalid,
    output logic        ext_awready,
    input  logic [31:0] ext_awaddr,
    input  logic        ext_wvalid,
    output logic        ext_wready,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_wstrb,
    output logic        ext_bvalid,
    input  logic        ext_bready,
    input  logic        ext_arvalid,
    output logic        ext_arready,
    input  logic [31:0] ext_araddr,
    output logic        ext_rvalid,
    input  logic        ext_rready,
    output logic [31:0] ext_rdata,
    output logic [31:0] ctrl_o,
    input  logic [31:0] status_i,
    output logic        irq_o
);

    logic             wr_commit;
    logic [31:0]      wr_addr, wr_data;
    logic [3:0]       wr_strb;
    logic             wr_hit, rd_hit, ar_hs;
    reg_off_e         wr_off, rd_off;
    logic [31:0]      ctrl_q, ctrl_d, irq_en_q, irq_en_d;
    logic [2:0][31:0] scratch_q, scratch_d;
    logic [31:0]      rdata_q, rdata_d, rd_val, cycles_val;
    logic             rvalid_q, rvalid_d, irq_q, irq_d;
    logic             unused_addr_bits;

    axil_wr_capture u_wr_capture (
        .clk           (clk),
        .resetn        (resetn),
        .awvalid_i     (ext_awvalid),
        .awready_o     (ext_awready),
        .awaddr_i      (ext_awaddr),
        .wvalid_i      (ext_wvalid),
        .wready_o      (ext_wready),
        .wdata_i       (ext_wdata),
        .wstrb_i       (ext_wstrb),
        .bvalid_o      (ext_bvalid),
        .bready_i      (ext_bready),
        .commit_o      (wr_commit),
        .commit_addr_o (wr_addr),
        .commit_data_o (wr_data),
        .commit_strb_o (wr_strb)
    );

    assign unused_addr_bits = ^{wr_addr[1:0], ext_araddr[1:0]};

    assign wr_hit = (wr_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign wr_off = reg_off_e'(wr_addr[WIN_BITS-1:2]);
    assign rd_hit = (ext_araddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign rd_off = reg_off_e'(ext_araddr[WIN_BITS-1:2]);

`ifdef AXIL_REG_SLAVE_CYCLES_EN
    logic [31:0] cycles_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycles_q <= '0;
        else         cycles_q <= cycles_q + 32'd1;
    end
    assign cycles_val = cycles_q;
`else
    assign cycles_val = '0;
`endif

    // RO offsets and out-of-window writes fall through untouched but are still acknowledged.
    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        if (wr_commit && wr_hit) begin
            case (wr_off)
                OFF_CTRL:     ctrl_d       = strb_merge(ctrl_q, wr_data, wr_strb);
                OFF_IRQ_EN:   irq_en_d     = strb_merge(irq_en_q, wr_data, wr_strb);
                OFF_SCRATCH0: scratch_d[0] = strb_merge(scratch_q[0], wr_data, wr_strb);
                OFF_SCRATCH1: scratch_d[1] = strb_merge(scratch_q[1], wr_data, wr_strb);
                OFF_SCRATCH2: scratch_d[2] = strb_merge(scratch_q[2], wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_hit) begin
            case (rd_off)
                OFF_CTRL:     rd_val = ctrl_q;
                OFF_IRQ_EN:   rd_val = irq_en_q;
                OFF_STATUS:   rd_val = status_i;
                OFF_SCRATCH0: rd_val = scratch_q[0];
                OFF_SCRATCH1: rd_val = scratch_q[1];
                OFF_SCRATCH2: rd_val = scratch_q[2];
                OFF_ID:       rd_val = ID_VALUE;
                OFF_CYCLES:   rd_val = cycles_val;
                default:      rd_val = '0;
            endcase
        end
    end

    // Read samples pre-write register values, so a same-edge commit is not visible.
    assign ext_arready = !rvalid_q;
    assign ar_hs       = ext_arvalid && ext_arready;

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && ext_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end
        irq_d = |(status_i & irq_en_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q    <= '0;
            irq_en_q  <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
        end
    end

    assign ext_rvalid = rvalid_q;
    assign ext_rdata  = rdata_q;
    assign ctrl_o     = ctrl_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - randomized self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] ID   = 32'h4E41_0001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ext_awvalid, ext_awready;
    logic [31:0] ext_awaddr;
    logic        ext_wvalid, ext_wready;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_wstrb;
    logic        ext_bvalid, ext_bready;
    logic        ext_arvalid, ext_arready;
    logic [31:0] ext_araddr;
    logic        ext_rvalid, ext_rready;
    logic [31:0] ext_rdata;
    logic [31:0] ctrl_o, status_i;
    logic        irq_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    logic [31:0] m_reg [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    axil_reg_slave dut (
        .clk         (clk),
        .resetn      (resetn),
        .ext_awvalid (ext_awvalid),
        .ext_awready (ext_awready),
        .ext_awaddr  (ext_awaddr),
        .ext_wvalid  (ext_wvalid),
        .ext_wready  (ext_wready),
        .ext_wdata   (ext_wdata),
        .ext_wstrb   (ext_wstrb),
        .ext_bvalid  (ext_bvalid),
        .ext_bready  (ext_bready),
        .ext_arvalid (ext_arvalid),
        .ext_arready (ext_arready),
        .ext_araddr  (ext_araddr),
        .ext_rvalid  (ext_rvalid),
        .ext_rready  (ext_rready),
        .ext_rdata   (ext_rdata),
        .ctrl_o      (ctrl_o),
        .status_i    (status_i),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
    endfunction

    function automatic bit in_window(input logic [31:0] addr);
        return (addr >= BASE) && (addr < BASE + 32'h20);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        idx = int'((addr - BASE) / 4);
        if (!in_window(addr)) return;
        if (idx == 2 || idx >= 6) return;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        if (!in_window(addr)) return 32'd0;
        idx = int'((addr - BASE) / 4);
        if (idx == 2) return status_i;
        if (idx == 6) return ID;
        if (idx == 7) return 32'd0;
        return m_reg[idx];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          off;
        off = int'($urandom_range(0, 7));
`ifdef AXIL_REG_SLAVE_CYCLES_EN
        if (off == 7) off = 6;
`endif
        a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0)
            a = (($urandom_range(0, 1) == 1) ? 32'h0400_0000 : BASE + 32'h20) + 32'(off * 4);
        return a;
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        check("rst_awready", 32'(ext_awready), 1);
        check("rst_wready", 32'(ext_wready), 1);
        check("rst_arready", 32'(ext_arready), 1);
        check("rst_bvalid", 32'(ext_bvalid), 0);
        check("rst_rvalid", 32'(ext_rvalid), 0);
        check("rst_rdata", ext_rdata, 0);
        check("rst_irq", 32'(irq_o), 0);
        check("rst_ctrl", ctrl_o, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        ext_awaddr = addr;
        ext_wdata  = data;
        ext_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            ext_awvalid = !aw_done && (cyc >= aw_dly);
            ext_wvalid  = !w_done && (cyc >= w_dly);
            #1;
            aw_fire = ext_awvalid && ext_awready;
            w_fire  = ext_wvalid && ext_wready;
            @(posedge clk);
            #1;
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            cyc++;
            if (!(aw_done && w_done)) begin
                check("wr_bvalid_early", 32'(ext_bvalid), 0);
                if (aw_done) check("wr_awready_held", 32'(ext_awready), 0);
                if (w_done)  check("wr_wready_held", 32'(ext_wready), 0);
            end
        end
        ext_awvalid = 1'b0;
        ext_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        model_write(addr, data, strb);
        check("wr_bvalid", 32'(ext_bvalid), 1);
        check("wr_ctrl_o", ctrl_o, m_reg[0]);
        ext_bready = 1'b0;
        repeat (b_dly) begin
            @(posedge clk);
            #1;
            check("wr_bvalid_hold", 32'(ext_bvalid), 1);
            check("wr_awready_bpend", 32'(ext_awready), 0);
            check("wr_wready_bpend", 32'(ext_wready), 0);
        end
        ext_bready = 1'b1;
        @(posedge clk);
        #1;
        ext_bready = 1'b0;
        check("wr_bvalid_clr", 32'(ext_bvalid), 0);
        check("wr_awready_free", 32'(ext_awready), 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rr_dly, input bit cmp,
                            output logic [31:0] data, output int hs_cyc);
        bit          fire;
        int          cyc;
        logic [31:0] exp;
        fire   = 0;
        cyc    = 0;
        data   = '0;
        hs_cyc = 0;
        exp    = '0;
        ext_araddr  = addr;
        ext_arvalid = 1'b1;
        while (!fire && cyc < 40) begin
            #1;
            exp  = model_read(addr);
            fire = ext_arready;
            @(posedge clk);
            #1;
            cyc++;
        end
        ext_arvalid = 1'b0;
        if (!fire) begin
            check("rd_handshake_timeout", 0, 1);
            return;
        end
        hs_cyc = cyc_cnt;
        check("rd_rvalid", 32'(ext_rvalid), 1);
        if (cmp) check("rd_rdata", ext_rdata, exp);
        data = ext_rdata;
        repeat (rr_dly) begin
            @(posedge clk);
            #1;
            check("rd_rvalid_hold", 32'(ext_rvalid), 1);
            check("rd_arready_busy", 32'(ext_arready), 0);
            check("rd_rdata_hold", ext_rdata, data);
        end
        ext_rready = 1'b1;
        @(posedge clk);
        #1;
        ext_rready = 1'b0;
        check("rd_rvalid_clr", 32'(ext_rvalid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, v1, v2, wd;
        int          h1, h2;
        ext_awvalid = 0; ext_awaddr = '0;
        ext_wvalid  = 0; ext_wdata  = '0; ext_wstrb = '0;
        ext_bready  = 0;
        ext_arvalid = 0; ext_araddr = '0;
        ext_rready  = 0;
        status_i    = '0;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        axi_write(BASE, 32'hA5A5_0001, 4'hF, 0, 0, 0);
        check("ctrl_first", ctrl_o, 32'hA5A5_0001);
        axi_read(BASE, 0, 1, rd, h1);
        check("ctrl_readback", rd, 32'hA5A5_0001);

        axi_write(BASE + 32'h0C, 32'h1122_3344, 4'h5, 3, 0, 0);
        axi_read(BASE + 32'h0C, 1, 1, rd, h1);
        check("scratch0_strb", rd, 32'h0022_0044);

        axi_write(BASE + 32'h10, $urandom, 4'hF, 0, 2, 5);
        axi_read(BASE + 32'h10, 0, 1, rd, h1);

        axi_read(BASE + 32'h18, 0, 1, rd, h1);
        check("id_value", rd, 32'h4E41_0001);
        axi_read(32'h0400_0000, 0, 1, rd, h1);
        check("outside_zero", rd, 32'd0);
        status_i = 32'h1357_9BDF;
        axi_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        axi_read(BASE + 32'h08, 0, 1, rd, h1);
        check("status_ro", rd, 32'h1357_9BDF);

        status_i = '0;
        axi_write(BASE + 32'h04, 32'h0000_0004, 4'hF, 0, 0, 0);
        check("irq_idle", 32'(irq_o), 0);
        status_i = 32'h0000_0004;
        #1;
        check("irq_lag", 32'(irq_o), 0);
        @(posedge clk);
        #1;
        check("irq_set", 32'(irq_o), 1);
        status_i = 32'h0000_0003;
        @(posedge clk);
        #1;
        check("irq_masked", 32'(irq_o), 0);

        axi_read(BASE + 32'h1C, 0, 0, v1, h1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        axi_read(BASE + 32'h1C, 0, 0, v2, h2);
        check("cycles_gap", 32'(h2 - h1), 10);
`ifdef AXIL_REG_SLAVE_CYCLES_EN
        check("cycles_delta", v2 - v1, 32'(h2 - h1));
`else
        check("cycles_zero_a", v1, 0);
        check("cycles_zero_b", v2, 0);
`endif

        ext_awaddr  = BASE + 32'h10;
        ext_awvalid = 1'b1;
        @(posedge clk);
        #1;
        ext_awvalid = 1'b0;
        check("abort_aw_held", 32'(ext_awready), 0);
        resetn = 1'b0;
        #1;
        check("abort_bvalid", 32'(ext_bvalid), 0);
        check("abort_held_clr", 32'(ext_awready), 1);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        axi_write(BASE + 32'h14, 32'hCAFE_F00D, 4'hF, 4, 0, 0);
        axi_read(BASE + 32'h10, 0, 1, rd, h1);
        check("abort_no_commit", rd, 32'd0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) status_i = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                axi_write(rand_addr(), wd, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
            end else begin
                axi_read(rand_addr(), int'($urandom_range(0, 2)), 1, rd, h1);
            end
            check("rand_irq", 32'(irq_o), 32'(|(status_i & m_reg[1])));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
